// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared types and constants for the scoreboarded register file.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Two-state controller: zeroing sweep, then normal operation.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index of the write port that wins when both target the same register.
  localparam int PORT_PRI = 1;

  // Address width for a register count; never narrower than one bit.
  function automatic int calc_aw(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Per-register busy bits with issue-set / writeback-clear and
//             NRP busy read muxes. Register 0 is never busy.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = calc_aw(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    set_en_i,
  input  logic [AW-1:0]           set_addr_i,
  input  logic [1:0]              clr_en_i,
  input  logic [1:0][AW-1:0]      clr_addr_i,
  input  logic [NRP-1:0][AW-1:0]  ra_i,
  output logic [NRP-1:0]          busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clears first, then the issue set so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      for (int k = 0; k < 2; k++) begin
        if (clr_en_i[k]) busy_d[clr_addr_i[k]] = 1'b0;
      end
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    assign busy_o[i] = busy_q[ra_i[i]];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Scoreboarded RV32I register file: NRP combinational read ports,
//             two prioritised write ports, reset-time zeroing sweep.
//             Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic [NRP-1:0][AW-1:0]   ra,
  output logic [NRP-1:0][XLEN-1:0] rd,
  output logic [NRP-1:0]           rbusy,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     we0,
  input  logic [AW-1:0]            wa0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     we1,
  input  logic [AW-1:0]            wa1,
  input  logic [XLEN-1:0]          wd1
);

  localparam int c_hi = PORT_PRI;
  localparam int c_lo = 1 - PORT_PRI;

  state_e              state_q;
  logic [AW-1:0]       idx_q;
  logic                ready_q;
  logic [XLEN-1:0]     rf_q [NREG];

  logic                  w_run;
  logic [1:0]            w_we;
  logic [1:0][AW-1:0]    w_wa;
  logic [1:0][XLEN-1:0]  w_wd;
  logic [1:0]            w_commit;
  logic [NRP-1:0]        w_sb_busy;

  assign w_run = (state_q == ST_RUN);
  assign w_we  = {we1, we0};
  assign w_wa  = {wa1, wa0};
  assign w_wd  = {wd1, wd0};

  // A write commits only in RUN and never to register 0.
  assign w_commit[0] = w_run && w_we[0] && (w_wa[0] != '0);
  assign w_commit[1] = w_run && w_we[1] && (w_wa[1] != '0);

  assign ready = ready_q;

  // Controller: sweep index through every entry, then enter RUN and flag ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(NREG - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Storage: zero during the sweep; in RUN the priority port is written last.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      rf_q[idx_q] <= '0;
    end else begin
      if (w_commit[c_lo]) rf_q[w_wa[c_lo]] <= w_wd[c_lo];
      if (w_commit[c_hi]) rf_q[w_wa[c_hi]] <= w_wd[c_hi];
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (w_run),
    .set_en_i   (iss_en && (iss_addr != '0)),
    .set_addr_i (iss_addr),
    .clr_en_i   (w_commit),
    .clr_addr_i (w_wa),
    .ra_i       (ra),
    .busy_o     (w_sb_busy)
  );

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic w_hit_hi;
    logic w_hit_lo;
    logic w_sel_st;

`ifdef REGFILE_BYPASS_EN
    assign w_hit_hi = w_commit[c_hi] && (w_wa[c_hi] == ra[i]);
    assign w_hit_lo = w_commit[c_lo] && (w_wa[c_lo] == ra[i]);
`else
    assign w_hit_hi = 1'b0;
    assign w_hit_lo = 1'b0;
`endif

    // Stored value is only visible in RUN and for nonzero addresses.
    assign w_sel_st = w_run && (ra[i] != '0);

    assign rd[i] = w_hit_hi ? w_wd[c_hi] :
                   w_hit_lo ? w_wd[c_lo] :
                   w_sel_st ? rf_q[ra[i]] : '0;

    // A bypassed read is by definition no longer waiting on its producer.
    assign rbusy[i] = (w_sel_st && !w_hit_hi && !w_hit_lo) ? w_sb_busy[i] : 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Directed self-checking bench for regfile_sb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ready;
  logic [NRP-1:0][AW-1:0]   ra;
  logic [NRP-1:0][XLEN-1:0] rd;
  logic [NRP-1:0]           rbusy;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     we0, we1;
  logic [AW-1:0]            wa0, wa1;
  logic [XLEN-1:0]          wd0, wd1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    ra = '0; iss_addr = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rbusy", 32'(rbusy), 32'd0);
    rst_n = 1'b1;

    // Init sweep: ready low for 31 edges, high on the 32nd; inputs ignored
    for (int e = 1; e <= NREG; e++) begin
      if (e <= 20) begin
        iss_en = 1'b1; iss_addr = 5'd4; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h5555;
        ra[0] = 5'd4;
      end else begin
        idle();
      end
      tick();
      chk("init_ready", 32'(ready), (e == NREG) ? 32'd1 : 32'd0);
      if (e < NREG) begin
        #1;
        chk("init_rd_zero", rd[0], 32'd0);
        chk("init_rbusy_zero", 32'(rbusy[0]), 32'd0);
      end
    end
    #1;
    chk("post_init_busy4", 32'(rbusy[0]), 32'd0);
    chk("post_init_rd4", rd[0], 32'd0);

    // Every register reads zero after the sweep
    for (int r = 0; r < NREG; r++) begin
      ra[0] = AW'(r); ra[1] = AW'(NREG - 1 - r);
      #1;
      chk("sweep_rd0", rd[0], 32'd0);
      chk("sweep_rd1", rd[1], 32'd0);
    end

    // Simple write, visible next cycle
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra[0] = 5'd5;
    #1;
    chk("wr5_same_cycle", rd[0], BYP ? 32'hDEADBEEF : 32'd0);
    tick(); idle();
    #1;
    chk("wr5_next_cycle", rd[0], 32'hDEADBEEF);

    // Write to register 0 is dropped, even on the bypass path
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra[0] = 5'd0;
    #1;
    chk("wr0_same_cycle", rd[0], 32'd0);
    tick(); idle();
    #1;
    chk("wr0_next_cycle", rd[0], 32'd0);

    // Both ports to register 7: port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra[1] = 5'd7;
    #1;
    chk("pri7_same_cycle", rd[1], BYP ? 32'h22 : 32'd0);
    tick(); idle();
    #1;
    chk("pri7_next_cycle", rd[1], 32'h22);

    // Issue to 9, then load writeback to 9
    iss_en = 1'b1; iss_addr = 5'd9; ra[0] = 5'd9;
    #1;
    chk("iss9_same_cycle", 32'(rbusy[0]), 32'd0);
    tick(); idle();
    #1;
    chk("iss9_busy", 32'(rbusy[0]), 32'd1);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hCAFEF00D;
    #1;
    chk("wb9_rbusy", 32'(rbusy[0]), BYP ? 32'd0 : 32'd1);
    chk("wb9_rd", rd[0], BYP ? 32'hCAFEF00D : 32'd0);
    tick(); idle();
    #1;
    chk("wb9_busy_clear", 32'(rbusy[0]), 32'd0);
    chk("wb9_rd_next", rd[0], 32'hCAFEF00D);

    // Same-cycle issue and write to 3: set wins, data stored
    iss_en = 1'b1; iss_addr = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33; ra[0] = 5'd3;
    #1;
    chk("iss3_wr_rbusy", 32'(rbusy[0]), 32'd0);
    chk("iss3_wr_rd", rd[0], BYP ? 32'h33 : 32'd0);
    tick(); idle();
    #1;
    chk("iss3_busy_set", 32'(rbusy[0]), 32'd1);
    chk("iss3_rd", rd[0], 32'h33);

    // ALU writeback clears busy on 3
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h44;
    tick(); idle();
    #1;
    chk("wb3_busy_clear", 32'(rbusy[0]), 32'd0);
    chk("wb3_rd", rd[0], 32'h44);

    // Mid-run reset with busy bits set and a write in flight
    iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    iss_addr = 5'd13;
    tick(); idle();
    ra[0] = 5'd12; ra[1] = 5'd13;
    #1;
    chk("pre_rst_busy12", 32'(rbusy[0]), 32'd1);
    chk("pre_rst_busy13", 32'(rbusy[1]), 32'd1);
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hABCD;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rbusy", 32'(rbusy), 32'd0);
    chk("midrst_rd0", rd[0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; idle();
    for (int e = 1; e <= NREG; e++) begin
      tick();
      chk("resweep_ready", 32'(ready), (e == NREG) ? 32'd1 : 32'd0);
    end
    ra[0] = 5'd5; ra[1] = 5'd20;
    #1;
    chk("resweep_rd5", rd[0], 32'd0);
    chk("resweep_rd20", rd[1], 32'd0);
    ra[0] = 5'd7; ra[1] = 5'd12;
    #1;
    chk("resweep_rd7", rd[0], 32'd0);
    chk("resweep_busy12", 32'(rbusy[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
